core_regfile_commit: RTL

- Parametrised architectural/renamed register file with commit logic for the out-of-order core.
- Merges N executer write-back ports and one memory-load write-back port into the physical register array plus the stack pointer.
- Holds the rename base state and arbitrates jump redirects from the executers into one registered redirect (address, executer index, restored rename state).
- Adds deterministic collision priority and sticky error flags.

---
 rtl/core_regfile_commit_if.sv | 73 +++++++
 rtl/core_regfile_commit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_regfile_commit_if.sv
`default_nettype none
// ============================================================================
//  Module      : core_regfile_commit_if
//  Description : Bundle of every signal exchanged between the dispatcher /
//                executer cluster and the register-file commit block.
//                The master side drives write-back, rename and jump requests.
//                The slave side is the commit block, which returns register
//                state, the registered redirect and sticky error flags.
//  Ports (slave view):
//    in  ex_wr_valid/idx/data     N executer write-back ports
//    in  mem_wr_valid/idx/data    memory-load write-back port
//    in  rename_adv_valid/state   dispatcher rename advance
//    in  jump_req/addr/rename     executer redirect requests
//    in  err_clear                clears sticky error flags
//    out reg_values, stack_pointer, rename_base
//    out jump_valid, jump_target, jump_index
//    out err_write_collision, err_multi_jump, err_illegal_write
//  Revision    : 1.0 - initial release
// ============================================================================
interface core_regfile_commit_if #(
    parameter int NUM_EXEC  = 8,
    parameter int NUM_ARCH  = 16,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 32,
    parameter int IDX_W     = $clog2(2*NUM_ARCH+1),
    parameter int JIDX_W    = (NUM_EXEC > 1) ? $clog2(NUM_EXEC) : 1
);
    logic [NUM_EXEC-1:0]            ex_wr_valid;
    logic [NUM_EXEC*IDX_W-1:0]      ex_wr_idx;
    logic [NUM_EXEC*DATA_W-1:0]     ex_wr_data;
    logic                           mem_wr_valid;
    logic [IDX_W-1:0]               mem_wr_idx;
    logic [DATA_W-1:0]              mem_wr_data;
    logic                           rename_adv_valid;
    logic [NUM_ARCH-1:0]            rename_adv_state;
    logic [NUM_EXEC-1:0]            jump_req;
    logic [NUM_EXEC*ADDR_W-1:0]     jump_addr;
    logic [NUM_EXEC*NUM_ARCH-1:0]   jump_rename;
    logic                           err_clear;

    logic [2*NUM_ARCH*DATA_W-1:0]   reg_values;
    logic [DATA_W-1:0]              stack_pointer;
    logic [NUM_ARCH-1:0]            rename_base;
    logic                           jump_valid;
    logic [ADDR_W-1:0]              jump_target;
    logic [JIDX_W-1:0]              jump_index;
    logic                           err_write_collision;
    logic                           err_multi_jump;
    logic                           err_illegal_write;

    modport master (
        output ex_wr_valid, ex_wr_idx, ex_wr_data,
        output mem_wr_valid, mem_wr_idx, mem_wr_data,
        output rename_adv_valid, rename_adv_state,
        output jump_req, jump_addr, jump_rename,
        output err_clear,
        input  reg_values, stack_pointer, rename_base,
        input  jump_valid, jump_target, jump_index,
        input  err_write_collision, err_multi_jump, err_illegal_write
    );

    modport slave (
        input  ex_wr_valid, ex_wr_idx, ex_wr_data,
        input  mem_wr_valid, mem_wr_idx, mem_wr_data,
        input  rename_adv_valid, rename_adv_state,
        input  jump_req, jump_addr, jump_rename,
        input  err_clear,
        output reg_values, stack_pointer, rename_base,
        output jump_valid, jump_target, jump_index,
        output err_write_collision, err_multi_jump, err_illegal_write
    );
endinterface
`default_nettype wire

// File: rtl/core_regfile_commit.sv
`default_nettype none
// ============================================================================
//  Module      : core_regfile_commit
//  Description : Physical register file and commit logic for the OoO core.
//                Merges NUM_EXEC executer write-back ports plus one memory
//                load port into 2*NUM_ARCH physical registers and the stack
//                pointer, keeps the rename base state, and turns executer
//                jump requests into one registered redirect.
//  Ports:
//    main_clk      clock
//    main_reset_n  asynchronous active-low reset
//    cmt_bus       core_regfile_commit_if.slave (all data/handshake signals)
//  Revision    : 1.0 - initial release
// ============================================================================
module core_regfile_commit #(
    parameter int NUM_EXEC  = 8,
    parameter int NUM_ARCH  = 16,
    parameter int FIXED_LOW = 2,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 32,
    parameter int IDX_W     = $clog2(2*NUM_ARCH+1),
    parameter int JIDX_W    = (NUM_EXEC > 1) ? $clog2(NUM_EXEC) : 1
) (
    input  logic                  main_clk,
    input  logic                  main_reset_n,
    core_regfile_commit_if.slave  cmt_bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_num_phys = 2 * NUM_ARCH;

    // Index c_num_phys addresses the stack pointer rather than a register.
    localparam logic [IDX_W-1:0] c_sp_idx    = IDX_W'(c_num_phys);
    // Shadow copies of the never-renamed registers: [c_shadow_lo, c_shadow_hi)
    localparam logic [IDX_W-1:0] c_shadow_lo = IDX_W'(NUM_ARCH);
    localparam logic [IDX_W-1:0] c_shadow_hi = IDX_W'(NUM_ARCH + FIXED_LOW);

    // Fixed architectural registers are never renamed, so their rename bits
    // are held at 0 regardless of what the dispatcher or a jump supplies.
    localparam logic [NUM_ARCH-1:0] c_rename_mask = {NUM_ARCH{1'b1}} << FIXED_LOW;

    // ------------------------------------------------------------------------
    // Write merge helpers
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic              hit;
        logic              coll;
        logic [DATA_W-1:0] data;
    } merge_t;

    function automatic logic f_is_shadow(input logic [IDX_W-1:0] idx);
        return (idx >= c_shadow_lo) && (idx < c_shadow_hi);
    endfunction

    // Resolve every legal writer aimed at one target index. Executers are
    // scanned from 0 upward and the first hit keeps the slot, so the lowest
    // executer wins; the memory port only lands if no executer hit. Any
    // second hit on the same target flags a collision.
    function automatic merge_t f_merge(
        input logic [IDX_W-1:0]           tgt,
        input logic [NUM_EXEC-1:0]        ex_ok,
        input logic [NUM_EXEC*IDX_W-1:0]  ex_idx,
        input logic [NUM_EXEC*DATA_W-1:0] ex_data,
        input logic                       mem_ok,
        input logic [IDX_W-1:0]           mem_idx,
        input logic [DATA_W-1:0]          mem_data
    );
        merge_t m;
        m = '0;
        for (int e = 0; e < NUM_EXEC; e++) begin
            if (ex_ok[e] && (ex_idx[e*IDX_W +: IDX_W] == tgt)) begin
                if (m.hit) begin
                    m.coll = 1'b1;
                end else begin
                    m.hit  = 1'b1;
                    m.data = ex_data[e*DATA_W +: DATA_W];
                end
            end
        end
        if (mem_ok && (mem_idx == tgt)) begin
            if (m.hit) begin
                m.coll = 1'b1;
            end else begin
                m.hit  = 1'b1;
                m.data = mem_data;
            end
        end
        return m;
    endfunction

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [c_num_phys-1:0][DATA_W-1:0] r_regs;
    logic [DATA_W-1:0]                 r_sp;
    logic [NUM_ARCH-1:0]               r_rename_base;
    logic                              r_jump_valid;
    logic [ADDR_W-1:0]                 r_jump_target;
    logic [JIDX_W-1:0]                 r_jump_index;
    logic                              r_err_write_collision;
    logic                              r_err_multi_jump;
    logic                              r_err_illegal_write;

    // ------------------------------------------------------------------------
    // Write legality
    // ------------------------------------------------------------------------
    logic [NUM_EXEC-1:0] w_ex_ok;
    logic                w_mem_ok;
    logic                w_illegal;

    always_comb begin
        w_ex_ok   = '0;
        w_illegal = 1'b0;
        for (int e = 0; e < NUM_EXEC; e++) begin
            // Executers may target any register or the stack pointer.
            w_ex_ok[e] = cmt_bus.ex_wr_valid[e]
                      && (cmt_bus.ex_wr_idx[e*IDX_W +: IDX_W] <= c_sp_idx)
                      && !f_is_shadow(cmt_bus.ex_wr_idx[e*IDX_W +: IDX_W]);
            if (cmt_bus.ex_wr_valid[e] && !w_ex_ok[e]) begin
                w_illegal = 1'b1;
            end
        end
        // The load port cannot reach the stack pointer.
        w_mem_ok = cmt_bus.mem_wr_valid
                && (cmt_bus.mem_wr_idx < c_sp_idx)
                && !f_is_shadow(cmt_bus.mem_wr_idx);
        if (cmt_bus.mem_wr_valid && !w_mem_ok) begin
            w_illegal = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Per-target merge (targets 0..c_num_phys, last one is the stack pointer)
    // ------------------------------------------------------------------------
    merge_t w_merge [0:c_num_phys];
    logic   w_collision;

    always_comb begin
        w_collision = 1'b0;
        for (int t = 0; t <= c_num_phys; t++) begin
            w_merge[t] = f_merge(IDX_W'(t), w_ex_ok,
                                 cmt_bus.ex_wr_idx, cmt_bus.ex_wr_data,
                                 w_mem_ok, cmt_bus.mem_wr_idx,
                                 cmt_bus.mem_wr_data);
            w_collision = w_collision | w_merge[t].coll;
        end
    end

    // ------------------------------------------------------------------------
    // Jump arbitration
    // ------------------------------------------------------------------------
    logic                w_jump_any;
    logic                w_multi_jump;
    logic [JIDX_W-1:0]   w_jump_sel;
    logic [ADDR_W-1:0]   w_jump_addr;
    logic [NUM_ARCH-1:0] w_jump_rename;

    assign w_jump_any   = |cmt_bus.jump_req;
    // Clearing the lowest set bit leaves something only if 2+ bits were set.
    assign w_multi_jump = (cmt_bus.jump_req & (cmt_bus.jump_req - NUM_EXEC'(1))) != '0;

    always_comb begin
        w_jump_sel  = '0;
        w_jump_addr = '0;
        // Descending scan: the last assignment made is the lowest requester.
        for (int e = NUM_EXEC - 1; e >= 0; e--) begin
            if (cmt_bus.jump_req[e]) begin
                w_jump_sel  = JIDX_W'(e);
                w_jump_addr = cmt_bus.jump_addr[e*ADDR_W +: ADDR_W];
            end
        end
    end

    // Rename restore uses the winner latched last cycle; the rename vector
    // itself is taken live from that executer one cycle after its request.
    always_comb begin
        w_jump_rename = '0;
        for (int e = 0; e < NUM_EXEC; e++) begin
            if (r_jump_index == JIDX_W'(e)) begin
                w_jump_rename = cmt_bus.jump_rename[e*NUM_ARCH +: NUM_ARCH];
            end
        end
    end

    // ------------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------------
    always_ff @(posedge main_clk or negedge main_reset_n) begin
        if (!main_reset_n) begin
            r_regs                <= '0;
            r_sp                  <= '0;
            r_rename_base         <= '0;
            r_jump_valid          <= 1'b0;
            r_jump_target         <= '0;
            r_jump_index          <= '0;
            r_err_write_collision <= 1'b0;
            r_err_multi_jump      <= 1'b0;
            r_err_illegal_write   <= 1'b0;
        end else begin
            // Shadow slots can never be hit (their writes are illegal), the
            // extra guard just keeps them visibly constant.
            for (int t = 0; t < c_num_phys; t++) begin
                if (w_merge[t].hit && !f_is_shadow(IDX_W'(t))) begin
                    r_regs[t] <= w_merge[t].data;
                end
            end

            // Stack pointer stays half-word aligned.
            if (w_merge[c_num_phys].hit) begin
                r_sp <= {w_merge[c_num_phys].data[DATA_W-1:1], 1'b0};
            end

            // A redirect being presented this cycle overrides dispatch advance.
            if (r_jump_valid) begin
                r_rename_base <= w_jump_rename & c_rename_mask;
            end else if (cmt_bus.rename_adv_valid) begin
                r_rename_base <= cmt_bus.rename_adv_state & c_rename_mask;
            end

            r_jump_valid <= w_jump_any;
            if (w_jump_any) begin
                r_jump_index  <= w_jump_sel;
                r_jump_target <= w_jump_addr;
            end

            // Sticky flags: a new error in the clearing cycle keeps the flag.
            r_err_write_collision <= (r_err_write_collision && !cmt_bus.err_clear) || w_collision;
            r_err_multi_jump      <= (r_err_multi_jump      && !cmt_bus.err_clear) || w_multi_jump;
            r_err_illegal_write   <= (r_err_illegal_write   && !cmt_bus.err_clear) || w_illegal;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign cmt_bus.reg_values          = r_regs;
    assign cmt_bus.stack_pointer       = r_sp;
    assign cmt_bus.rename_base         = r_rename_base;
    assign cmt_bus.jump_valid          = r_jump_valid;
    assign cmt_bus.jump_target         = r_jump_target;
    assign cmt_bus.jump_index          = r_jump_index;
    assign cmt_bus.err_write_collision = r_err_write_collision;
    assign cmt_bus.err_multi_jump      = r_err_multi_jump;
    assign cmt_bus.err_illegal_write   = r_err_illegal_write;

endmodule
`default_nettype wire
